// File: rtl/vga_capture.sv
// VGA timing recovery and pixel capture: input stage, sync counters, lock FSM, registered capture outputs.
// Optional statistics outputs (frame_count, err_count) are enabled by defining VGA_CAPTURE_STATS_EN.
module vga_capture #(
  parameter int H_DATA_START = 144,
  parameter int H_DATA_END   = 784,
  parameter int H_TOTAL      = 800,
  parameter int H_TOL        = 2,
  parameter int V_DATA_START = 35,
  parameter int V_DATA_END   = 515,
  parameter int V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [2:0]  vga_rgb,
  output logic [9:0]  cap_col,
  output logic [9:0]  cap_row,
  output logic [2:0]  cap_rgb,
  output logic        cap_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
`ifdef VGA_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
`endif
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [10:0] LEN_MIN = 11'(H_TOTAL - H_TOL);
  localparam logic [10:0] LEN_MAX = 11'(H_TOTAL + H_TOL);
  localparam logic [9:0]  HS      = 10'(H_DATA_START);
  localparam logic [9:0]  HE      = 10'(H_DATA_END);
  localparam logic [9:0]  VS      = 10'(V_DATA_START);
  localparam logic [9:0]  VE      = 10'(V_DATA_END);
  localparam logic [9:0]  FRM_A   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  FRM_B   = 10'(V_TOTAL);

  logic        s1_hsync, s1_vsync;
  logic [2:0]  s1_rgb;
  logic        h_prev, v_prev;
  logic [9:0]  h_cnt, v_cnt;
  logic [1:0]  state, state_next;
  logic        lines_bad;

  logic        hfall, vfall;
  logic [9:0]  h_pos, v_line;
  logic [10:0] line_len;
  logic        line_bad, frame_good, active, lose_lock;

  // h_cnt/v_cnt hold the position of the previous s1 sample, so h_pos/v_line
  // give the position of the current s1 sample without an extra pipeline stage.
  always_comb begin
    hfall    = h_prev & ~s1_hsync;
    vfall    = v_prev & ~s1_vsync;
    line_len = {1'b0, h_cnt} + 11'd1;

    if (hfall)            h_pos = '0;
    else if (h_cnt == '1) h_pos = '1;
    else                  h_pos = h_cnt + 10'd1;

    if (vfall)                        v_line = '0;
    else if (hfall && (v_cnt != '1))  v_line = v_cnt + 10'd1;
    else                              v_line = v_cnt;

    // A line that runs past the tolerance is flagged before its hsync ever arrives.
    if (hfall) line_bad = (line_len < LEN_MIN) || (line_len > LEN_MAX);
    else       line_bad = ({1'b0, h_pos} > LEN_MAX);

    frame_good = (v_cnt == FRM_A) || (v_cnt == FRM_B);
    active     = (state == LOCKED) && (h_pos >= HS) && (h_pos < HE) &&
                 (v_line >= VS) && (v_line < VE);

    state_next = state;
    case (state)
      SEARCH:  if (vfall) state_next = CHECK;
      CHECK:   if (vfall && frame_good && !lines_bad && !line_bad) state_next = LOCKED;
      LOCKED:  if (line_bad || (vfall && !frame_good)) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
    lose_lock = (state == LOCKED) && (state_next == SEARCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_hsync    <= 1'b1;
      s1_vsync    <= 1'b1;
      s1_rgb      <= '0;
      h_prev      <= 1'b1;
      v_prev      <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= SEARCH;
      lines_bad   <= 1'b0;
      cap_col     <= '0;
      cap_row     <= '0;
      cap_rgb     <= '0;
      cap_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      s1_hsync    <= vga_hsync;
      s1_vsync    <= vga_vsync;
      s1_rgb      <= vga_rgb;
      h_prev      <= s1_hsync;
      v_prev      <= s1_vsync;
      h_cnt       <= h_pos;
      v_cnt       <= v_line;
      state       <= state_next;
      // Every vsync fall opens a fresh frame for line statistics.
      if (vfall)         lines_bad <= 1'b0;
      else if (line_bad) lines_bad <= 1'b1;
      cap_valid   <= active;
      cap_col     <= active ? (h_pos - HS) : '0;
      cap_row     <= active ? (v_line - VS) : '0;
      cap_rgb     <= active ? s1_rgb : '0;
      frame_start <= vfall;
      locked      <= (state_next == LOCKED);
      timing_err  <= lose_lock;
    end
  end

`ifdef VGA_CAPTURE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (vfall && (state_next == LOCKED)) frame_count <= frame_count + 16'd1;
      if (lose_lock && (err_count != '1))  err_count   <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using scaled-down timing (80x16) so several frames fit a short run.
module tb_vga_capture;

  localparam int HS_P    = 20;
  localparam int HE_P    = 60;
  localparam int H_TOT   = 80;
  localparam int H_TOL_P = 2;
  localparam int VS_P    = 3;
  localparam int VE_P    = 13;
  localparam int V_TOT   = 16;
  localparam int HSYNC_W = 12;

  logic       clk;
  logic       reset;
  logic       vga_hsync, vga_vsync;
  logic [2:0] vga_rgb;
  logic [9:0] cap_col, cap_row;
  logic [2:0] cap_rgb;
  logic       cap_valid, frame_start, locked, timing_err;
`ifdef VGA_CAPTURE_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  err_count;
`endif

  vga_capture #(
    .H_DATA_START(HS_P),
    .H_DATA_END  (HE_P),
    .H_TOTAL     (H_TOT),
    .H_TOL       (H_TOL_P),
    .V_DATA_START(VS_P),
    .V_DATA_END  (VE_P),
    .V_TOTAL     (V_TOT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_rgb    (vga_rgb),
    .cap_col    (cap_col),
    .cap_row    (cap_row),
    .cap_rgb    (cap_rgb),
    .cap_valid  (cap_valid),
    .frame_start(frame_start),
    .locked     (locked),
    .timing_err (timing_err)
`ifdef VGA_CAPTURE_STATS_EN
    ,
    .frame_count(frame_count),
    .err_count  (err_count)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned err_pulses = 0;
  int unsigned gen_frame = 32'hFFFF;
  int unsigned gen_v = 32'hFFFF;
  int unsigned gen_h = 32'hFFFF;
  bit gen_run = 0;
  bit gen_stop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (timing_err === 1'b1) err_pulses++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic skip(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int unsigned f, input int unsigned v, input int unsigned h, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (gen_frame == f && gen_v == v && gen_h == h) found = 1'b1;
    end
    if (!found) check_val({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  // Wait for the input sample (f,v,h) and move to the point where its outputs are visible.
  task automatic at_out(input int unsigned f, input int unsigned v, input int unsigned h, input string tag);
    wait_pos(f, v, h, tag);
    skip(2);
  endtask

  function automatic int unsigned len_of(input int unsigned f, input int unsigned v);
    if (f == 2 && v == 5) return H_TOT - 1;
    if (f == 3 && v == 6) return H_TOT + 10;
    return H_TOT;
  endfunction

  initial begin : generator
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
    vga_rgb   = '0;
    wait (gen_run);
    for (int unsigned f = 0; f < 12 && !gen_stop; f++)
      for (int unsigned v = 0; v < V_TOT && !gen_stop; v++)
        for (int unsigned h = 0; h < len_of(f, v) && !gen_stop; h++) begin
          @(posedge clk);
          #1;
          gen_frame = f;
          gen_v     = v;
          gen_h     = h;
          vga_hsync = (h >= HSYNC_W);
          vga_vsync = (v >= 2);
          vga_rgb   = 3'((h + v) % 8);
        end
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_val("rst_locked", 32'(locked), 0);
    check_val("rst_valid", 32'(cap_valid), 0);
    check_val("rst_col", 32'(cap_col), 0);
    check_val("rst_fs", 32'(frame_start), 0);
    check_val("rst_terr", 32'(timing_err), 0);
    skip(3);
    reset = 1'b1;
    gen_run = 1'b1;

    // Frame 0 start: first vsync fall, search -> check
    at_out(0, 0, 0, "f0_start");
    check_val("f0_fs", 32'(frame_start), 1);
    check_val("f0_locked", 32'(locked), 0);
    skip(1);
    check_val("f0_fs_end", 32'(frame_start), 0);

    // Frame 1 start: second vsync fall, lock exactly two clocks later
    wait_pos(1, 0, 0, "f1_start");
    skip(1);
    check_val("lock_early", 32'(locked), 0);
    skip(1);
    check_val("lock_rise", 32'(locked), 1);
    check_val("f1_fs", 32'(frame_start), 1);

    at_out(1, 2, 20, "row_above");
    check_val("row_above_valid", 32'(cap_valid), 0);
    at_out(1, 3, 19, "col_left");
    check_val("col_left_valid", 32'(cap_valid), 0);
    check_val("col_left_col", 32'(cap_col), 0);
    skip(1);
    check_val("first_valid", 32'(cap_valid), 1);
    check_val("first_col", 32'(cap_col), 0);
    check_val("first_row", 32'(cap_row), 0);
    check_val("first_rgb", 32'(cap_rgb), 7);
    at_out(1, 7, 30, "mid");
    check_val("mid_col", 32'(cap_col), 10);
    check_val("mid_row", 32'(cap_row), 4);
    check_val("mid_rgb", 32'(cap_rgb), 5);
    at_out(1, 12, 59, "last");
    check_val("last_valid", 32'(cap_valid), 1);
    check_val("last_col", 32'(cap_col), 39);
    check_val("last_row", 32'(cap_row), 9);
    check_val("last_rgb", 32'(cap_rgb), 7);
    skip(1);
    check_val("past_valid", 32'(cap_valid), 0);
    check_val("past_row", 32'(cap_row), 0);

    // Frame 2 has a 79-clock line: lock held
    at_out(3, 0, 0, "f3_start");
    check_val("short_ok_locked", 32'(locked), 1);
    check_val("short_ok_errs", err_pulses, 0);

    // Frame 3 line 6 runs to 90 clocks: lock lost when position 83 is seen
    at_out(3, 6, 82, "long_edge");
    check_val("long_edge_locked", 32'(locked), 1);
    check_val("long_edge_terr", 32'(timing_err), 0);
    skip(1);
    check_val("long_terr", 32'(timing_err), 1);
    check_val("long_locked", 32'(locked), 0);
    skip(1);
    check_val("long_terr_end", 32'(timing_err), 0);
`ifdef VGA_CAPTURE_STATS_EN
    check_val("stat_frames", 32'(frame_count), 3);
    check_val("stat_errs", 32'(err_count), 1);
`endif

    at_out(4, 0, 0, "f4_start");
    check_val("relock_check", 32'(locked), 0);
    at_out(4, 3, 20, "f4_px");
    check_val("unlocked_valid", 32'(cap_valid), 0);
    at_out(5, 0, 0, "f5_start");
    check_val("relock", 32'(locked), 1);
    check_val("relock_errs", err_pulses, 1);

    // Asynchronous reset in the middle of an active line
    at_out(5, 8, 35, "pre_rst");
    check_val("pre_rst_valid", 32'(cap_valid), 1);
    check_val("pre_rst_col", 32'(cap_col), 15);
    check_val("pre_rst_row", 32'(cap_row), 5);
    check_val("pre_rst_rgb", 32'(cap_rgb), 3);
    #2 reset = 1'b0;
    #1;
    check_val("arst_locked", 32'(locked), 0);
    check_val("arst_valid", 32'(cap_valid), 0);
    check_val("arst_col", 32'(cap_col), 0);
    check_val("arst_row", 32'(cap_row), 0);
    check_val("arst_rgb", 32'(cap_rgb), 0);
    check_val("arst_fs", 32'(frame_start), 0);
    check_val("arst_terr", 32'(timing_err), 0);
    skip(3);
    reset = 1'b1;

    at_out(6, 0, 0, "f6_start");
    check_val("post_rst_locked", 32'(locked), 0);
    at_out(6, 3, 20, "f6_px");
    check_val("post_rst_valid", 32'(cap_valid), 0);
    at_out(7, 0, 0, "f7_start");
    check_val("post_rst_relock", 32'(locked), 1);
    at_out(7, 3, 20, "f7_px");
    check_val("f7_valid", 32'(cap_valid), 1);
    check_val("f7_row", 32'(cap_row), 0);

    // Syncs frozen high: counter overflows and lock drops
    gen_stop = 1'b1;
    skip(150);
    check_val("stuck_locked", 32'(locked), 0);
    check_val("stuck_errs", err_pulses, 2);
    check_val("stuck_valid", 32'(cap_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
